btb_upd_ctrl: RTL and testbench
===============================

Name: btb_upd_ctrl

Overview:
- Sequences branch-resolution updates into the BTB's single write port (wr_en / jmpsrc / jmpaddr).
- Two branch-resolution lanes may each resolve a taken branch in the same cycle. The BTB accepts one write per cycle and writes on the negative edge.
- This block queues, orders and merges lane updates in a small FIFO, then drains them one per cycle through a registered write stage.
- Write issue can be held off by fetch/flush logic.

Parameters:
PC_WIDTH, 32, width of jmpsrc/jmpaddr
FIFO_DEPTH, 4, update queue entries (power of two, >=2)
FIFO_PTR, 2, log2(FIFO_DEPTH)
CNT_WIDTH, 16, width of issued-write counter

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous active-high reset
i_upd_vld_1  input  1  lane 1 (older) resolved branch valid
i_upd_taken_1  input  1  lane 1 branch taken
i_upd_src_1  input  PC_WIDTH  lane 1 branch PC
i_upd_tgt_1  input  PC_WIDTH  lane 1 target PC
i_upd_vld_2  input  1  lane 2 (younger) resolved branch valid
i_upd_taken_2  input  1  lane 2 branch taken
i_upd_src_2  input  PC_WIDTH  lane 2 branch PC
i_upd_tgt_2  input  PC_WIDTH  lane 2 target PC
o_upd_rdy  output  1  both lanes may present updates this cycle
i_wr_hold  input  1  suppress issuing a BTB write this cycle
o_wr_en  output  1  BTB write enable (registered)
o_jmpsrc  output  PC_WIDTH  BTB write index/tag PC (registered)
o_jmpaddr  output  PC_WIDTH  BTB write target (registered)
o_busy  output  1  FIFO non-empty or o_wr_en high
o_wr_cnt  output  CNT_WIDTH  saturating count of issued writes

Behaviour:
- Reset (asynchronous, immediate):
  - count, rd_ptr and wr_ptr = 0.
  - o_wr_en = 0; o_jmpsrc = 0; o_jmpaddr = 0; o_wr_cnt = 0.
  - o_upd_rdy = 1; o_busy = 0.
  - Mid-operation reset discards all queued entries and any write in flight.
- Ready:
  - o_upd_rdy = (count <= FIFO_DEPTH-2), combinational from count only.
  - Upstream holds lane inputs while o_upd_rdy = 0.
  - Lane inputs with vld = 1 while o_upd_rdy = 0 are ignored, not enqueued.
- Accept:
  - Lane k is accepted when i_upd_vld_k & o_upd_rdy.
  - An accepted lane with taken = 0 is consumed with no enqueue. The BTB holds taken targets only.
- Enqueue order:
  - Lane 1 goes to wr_ptr; lane 2 goes to wr_ptr+1 (or wr_ptr if lane 1 does not enqueue).
  - Pointers wrap modulo FIFO_DEPTH.
- Merge:
  - If both lanes enqueue and i_upd_src_1 == i_upd_src_2, only the lane 2 entry is written (push of 1). Lane 2 is younger and wins.
  - No merging against entries already queued.
- Pop/issue, evaluated each posedge:
  - If count > 0 and !i_wr_hold, the head is popped and loaded into o_jmpsrc/o_jmpaddr, and o_wr_en <= 1.
  - Otherwise o_wr_en <= 0, and o_jmpsrc/o_jmpaddr keep their previous values.
  - The popped entry leaves the FIFO in that same cycle.
- Count:
  - count_next = count + push(0..2) - pop(0..1).
  - A push and a pop in the same cycle are legal. Entries never exceed FIFO_DEPTH, guaranteed by the ready rule.
- Latency:
  - An update accepted at posedge of cycle C is in the FIFO during C+1.
  - With no hold and an empty FIFO, o_wr_en = 1 during cycle C+2.
  - Sustained throughput is 1 write per cycle.
- Hold: i_wr_hold freezes issue only. Enqueue continues while ready.
- o_wr_cnt increments on each cycle o_wr_en is loaded with 1 and saturates at all-ones.
- o_busy = (count != 0) | o_wr_en.

Test Plan:
- Reset release, idle:
  - Required: o_wr_en = 0, o_upd_rdy = 1, o_busy = 0, o_wr_cnt = 0.
- Single update: lane 1 taken, src = 0x0000_1008, tgt = 0x0000_2000, in cycle 0.
  - Required: o_wr_en = 1 with 0x1008 / 0x2000 in cycle 2 only; o_wr_cnt = 1.
- Dual distinct updates: lane 1 src 0x100 / tgt 0x400, lane 2 src 0x108 / tgt 0x500, same cycle.
  - Required: writes of 0x100 then 0x108 in consecutive cycles 2 and 3.
- Dual same-source updates: src 0x200, lane 1 tgt 0x600, lane 2 tgt 0x700.
  - Required: exactly one write, 0x200 / 0x700. Not-taken lane: no write.
- Hold and full:
  - i_wr_hold = 1 while 2 dual updates arrive → count = 4, o_upd_rdy = 0 from count 3.
  - A third dual presentation is ignored.
  - Release hold → 4 writes in FIFO order on consecutive cycles, then o_busy = 0.
- Async reset with 3 entries queued and o_wr_en = 1:
  - Required: o_wr_en drops without a clock edge, and no stale writes occur after reset release.

Source files
------------

// File: rtl/btb_upd_ctrl.sv
// ---------------------------------------------------------------------------
// btb_upd_ctrl
//
// Purpose:
//   Funnels branch-resolution updates from two lanes into the single BTB
//   write port. Taken updates are queued in a small FIFO in lane order
//   (lane 1 older, lane 2 younger). Two same-cycle updates to the same
//   branch PC are merged so that only the younger target is stored. The FIFO
//   drains one entry per cycle into a registered write stage. i_wr_hold
//   pauses the drain; enqueue continues while there is room.
//
// Handshake:
//   o_upd_rdy is high when the FIFO has room for two more entries. Lane k is
//   accepted in a cycle where i_upd_vld_k and o_upd_rdy are both high at the
//   rising clock edge. Upstream holds its lane inputs while o_upd_rdy is low.
//   Lane inputs presented while o_upd_rdy is low are ignored. An accepted
//   update that is not taken is consumed without being queued.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_upd_vld/taken/src/tgt_1    lane 1 (older) branch resolution
//   i_upd_vld/taken/src/tgt_2    lane 2 (younger) branch resolution
//   o_upd_rdy                    both lanes may present updates this cycle
//   i_wr_hold                    suppress issuing a BTB write this cycle
//   o_wr_en, o_jmpsrc, o_jmpaddr registered BTB write port
//   o_busy                       FIFO non-empty or write in flight
//   o_wr_cnt                     saturating count of issued writes
// ---------------------------------------------------------------------------
module btb_upd_ctrl #(
    parameter int PC_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_PTR   = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_upd_vld_1,
    input  logic                 i_upd_taken_1,
    input  logic [PC_WIDTH-1:0]  i_upd_src_1,
    input  logic [PC_WIDTH-1:0]  i_upd_tgt_1,
    input  logic                 i_upd_vld_2,
    input  logic                 i_upd_taken_2,
    input  logic [PC_WIDTH-1:0]  i_upd_src_2,
    input  logic [PC_WIDTH-1:0]  i_upd_tgt_2,
    output logic                 o_upd_rdy,
    input  logic                 i_wr_hold,
    output logic                 o_wr_en,
    output logic [PC_WIDTH-1:0]  o_jmpsrc,
    output logic [PC_WIDTH-1:0]  o_jmpaddr,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_wr_cnt
);

    // Count needs one extra bit so that a full FIFO is distinguishable from empty.
    localparam int CW = FIFO_PTR + 1;

    logic [PC_WIDTH-1:0]  r_fifo_src [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]  r_fifo_tgt [FIFO_DEPTH];
    logic [FIFO_PTR-1:0]  r_rd_ptr;
    logic [FIFO_PTR-1:0]  r_wr_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_wr_en;
    logic [PC_WIDTH-1:0]  r_jmpsrc;
    logic [PC_WIDTH-1:0]  r_jmpaddr;
    logic [CNT_WIDTH-1:0] r_wr_cnt;

    logic                 w_rdy;
    logic                 w_enq_1;
    logic                 w_enq_2;
    logic                 w_merge;
    logic                 w_wr1;
    logic [1:0]           w_push;
    logic                 w_pop;
    logic [FIFO_PTR-1:0]  w_slot2;

    // Room for two entries is required so that a dual push can never overflow.
    assign w_rdy   = (r_count <= CW'(FIFO_DEPTH - 2));

    assign w_enq_1 = i_upd_vld_1 & w_rdy & i_upd_taken_1;
    assign w_enq_2 = i_upd_vld_2 & w_rdy & i_upd_taken_2;

    // Same branch PC resolved on both lanes: the younger lane 2 target wins,
    // so the lane 1 entry is dropped and only one slot is used.
    assign w_merge = w_enq_1 & w_enq_2 & (i_upd_src_1 == i_upd_src_2);
    assign w_wr1   = w_enq_1 & ~w_merge;
    assign w_push  = {1'b0, w_wr1} + {1'b0, w_enq_2};

    // Lane 2 lands right behind lane 1, or at the tail if lane 1 is not queued.
    assign w_slot2 = r_wr_ptr + FIFO_PTR'(w_wr1);

    // An entry pushed this cycle is not visible to the pop until the next cycle.
    assign w_pop   = (r_count != '0) & ~i_wr_hold;

    // Storage needs no reset: count and pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (w_wr1) begin
            r_fifo_src[r_wr_ptr] <= i_upd_src_1;
            r_fifo_tgt[r_wr_ptr] <= i_upd_tgt_1;
        end
        if (w_enq_2) begin
            r_fifo_src[w_slot2] <= i_upd_src_2;
            r_fifo_tgt[w_slot2] <= i_upd_tgt_2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_jmpsrc  <= '0;
            r_jmpaddr <= '0;
            r_wr_cnt  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + FIFO_PTR'(w_push);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_wr_en  <= w_pop;
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_jmpsrc  <= r_fifo_src[r_rd_ptr];
                r_jmpaddr <= r_fifo_tgt[r_rd_ptr];
                if (r_wr_cnt != '1) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
        end
    end

    assign o_upd_rdy = w_rdy;
    assign o_wr_en   = r_wr_en;
    assign o_jmpsrc  = r_jmpsrc;
    assign o_jmpaddr = r_jmpaddr;
    assign o_wr_cnt  = r_wr_cnt;
    assign o_busy    = (r_count != '0) | r_wr_en;

endmodule

// File: tb/tb_btb_upd_ctrl.sv
// Bench for btb_upd_ctrl. Inputs are driven 1 time unit after the rising
// edge; inline checks sample at the same point, and the write-port
// scoreboard samples on the falling edge.
module tb_btb_upd_ctrl;
  localparam int PW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          upd_vld_1, upd_taken_1, upd_vld_2, upd_taken_2;
  logic [PW-1:0] upd_src_1, upd_tgt_1, upd_src_2, upd_tgt_2;
  logic          upd_rdy;
  logic          wr_hold;
  logic          wr_en;
  logic [PW-1:0] jmpsrc, jmpaddr;
  logic          busy;
  logic [CW-1:0] wr_cnt;

  int total = 0;
  int bad   = 0;
  int rand_pushes = 0;

  logic [2*PW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  btb_upd_ctrl #(.PC_WIDTH(PW), .FIFO_DEPTH(4), .FIFO_PTR(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_upd_vld_1(upd_vld_1), .i_upd_taken_1(upd_taken_1),
    .i_upd_src_1(upd_src_1), .i_upd_tgt_1(upd_tgt_1),
    .i_upd_vld_2(upd_vld_2), .i_upd_taken_2(upd_taken_2),
    .i_upd_src_2(upd_src_2), .i_upd_tgt_2(upd_tgt_2),
    .o_upd_rdy(upd_rdy), .i_wr_hold(wr_hold),
    .o_wr_en(wr_en), .o_jmpsrc(jmpsrc), .o_jmpaddr(jmpaddr),
    .o_busy(busy), .o_wr_cnt(wr_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [2*PW-1:0] sb_exp;
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write src=%h tgt=%h expected no write", jmpsrc, jmpaddr);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({jmpsrc, jmpaddr} !== sb_exp) begin
          bad++;
          $display("FAIL sb_write got src=%h tgt=%h expected src=%h tgt=%h",
                   jmpsrc, jmpaddr, sb_exp[2*PW-1:PW], sb_exp[PW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lanes();
    upd_vld_1 = 0; upd_taken_1 = 0; upd_src_1 = '0; upd_tgt_1 = '0;
    upd_vld_2 = 0; upd_taken_2 = 0; upd_src_2 = '0; upd_tgt_2 = '0;
  endtask

  task automatic drive_lane1(input logic tk, input logic [PW-1:0] s, input logic [PW-1:0] t);
    upd_vld_1 = 1; upd_taken_1 = tk; upd_src_1 = s; upd_tgt_1 = t;
  endtask

  task automatic drive_lane2(input logic tk, input logic [PW-1:0] s, input logic [PW-1:0] t);
    upd_vld_2 = 1; upd_taken_2 = tk; upd_src_2 = s; upd_tgt_2 = t;
  endtask

  task automatic chk_wr(input string name, input logic exp_en);
    total++;
    if (wr_en !== exp_en) begin
      bad++;
      $display("FAIL %s wr_en=%b expected %b", name, wr_en, exp_en);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; wr_hold = 0; idle_lanes();
    repeat (3) tick();
    rst = 0;
    tick();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    total++; if (upd_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", upd_rdy); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (wr_cnt !== 16'd0) begin bad++; $display("FAIL reset_wr_cnt got=%0d exp=0", wr_cnt); end
    total++; if (jmpsrc !== '0 || jmpaddr !== '0) begin bad++; $display("FAIL reset_port got=%h/%h exp=0/0", jmpsrc, jmpaddr); end
  endtask

  task automatic test_single();
    drive_lane1(1, 32'h0000_1008, 32'h0000_2000);
    exp_q.push_back({32'h0000_1008, 32'h0000_2000});
    tick(); idle_lanes();                 // cycle 1: in FIFO
    chk_wr("single_c1", 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_c1 got=%b exp=1", busy); end
    tick();                               // cycle 2: write
    chk_wr("single_c2", 1'b1);
    total++; if (jmpsrc !== 32'h1008 || jmpaddr !== 32'h2000) begin bad++; $display("FAIL single_data got=%h/%h exp=1008/2000", jmpsrc, jmpaddr); end
    tick();
    chk_wr("single_c3", 1'b0);
    total++; if (wr_cnt !== 16'd1) begin bad++; $display("FAIL single_wr_cnt got=%0d exp=1", wr_cnt); end
  endtask

  task automatic test_dual_distinct();
    drive_lane1(1, 32'h100, 32'h400);
    drive_lane2(1, 32'h108, 32'h500);
    exp_q.push_back({32'h100, 32'h400});
    exp_q.push_back({32'h108, 32'h500});
    tick(); idle_lanes();
    chk_wr("dual_c1", 1'b0);
    tick();
    chk_wr("dual_c2", 1'b1);
    total++; if (jmpsrc !== 32'h100) begin bad++; $display("FAIL dual_first got=%h exp=100", jmpsrc); end
    tick();
    chk_wr("dual_c3", 1'b1);
    total++; if (jmpsrc !== 32'h108) begin bad++; $display("FAIL dual_second got=%h exp=108", jmpsrc); end
    tick();
    chk_wr("dual_c4", 1'b0);
  endtask

  task automatic test_merge_and_not_taken();
    drive_lane1(1, 32'h200, 32'h600);
    drive_lane2(1, 32'h200, 32'h700);
    exp_q.push_back({32'h200, 32'h700});
    tick(); idle_lanes();
    tick();
    chk_wr("merge_c2", 1'b1);
    total++; if (jmpaddr !== 32'h700) begin bad++; $display("FAIL merge_tgt got=%h exp=700", jmpaddr); end
    tick();
    chk_wr("merge_c3", 1'b0);
    // not-taken on lane 1, nothing should reach the BTB
    drive_lane1(0, 32'h240, 32'h800);
    tick(); idle_lanes();
    chk_wr("nt_c1", 1'b0);
    tick();
    chk_wr("nt_c2", 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nt_busy got=%b exp=0", busy); end
    total++; if (wr_cnt !== 16'd4) begin bad++; $display("FAIL merge_wr_cnt got=%0d exp=4", wr_cnt); end
  endtask

  task automatic test_hold_full();
    wr_hold = 1;
    drive_lane1(1, 32'hA00, 32'hB00);
    drive_lane2(1, 32'hA10, 32'hB10);
    exp_q.push_back({32'hA00, 32'hB00});
    exp_q.push_back({32'hA10, 32'hB10});
    tick();                               // count 2
    total++; if (upd_rdy !== 1'b1) begin bad++; $display("FAIL hold_rdy_cnt2 got=%b exp=1", upd_rdy); end
    drive_lane1(1, 32'hA20, 32'hB20);
    drive_lane2(1, 32'hA30, 32'hB30);
    exp_q.push_back({32'hA20, 32'hB20});
    exp_q.push_back({32'hA30, 32'hB30});
    tick();                               // count 4
    total++; if (upd_rdy !== 1'b0) begin bad++; $display("FAIL hold_rdy_full got=%b exp=0", upd_rdy); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", busy); end
    chk_wr("hold_no_issue", 1'b0);
    // third presentation, must be ignored
    drive_lane1(1, 32'hA40, 32'hB40);
    drive_lane2(1, 32'hA50, 32'hB50);
    tick(); tick();
    total++; if (upd_rdy !== 1'b0) begin bad++; $display("FAIL hold_rdy_still_full got=%b exp=0", upd_rdy); end
    idle_lanes();
    wr_hold = 0;
    tick();
    chk_wr("drain_1", 1'b1);
    total++; if (jmpsrc !== 32'hA00) begin bad++; $display("FAIL drain_1_src got=%h exp=a00", jmpsrc); end
    total++; if (upd_rdy !== 1'b0) begin bad++; $display("FAIL drain_rdy_cnt3 got=%b exp=0", upd_rdy); end
    tick();
    chk_wr("drain_2", 1'b1);
    total++; if (upd_rdy !== 1'b1) begin bad++; $display("FAIL drain_rdy_cnt2 got=%b exp=1", upd_rdy); end
    tick(); chk_wr("drain_3", 1'b1);
    tick(); chk_wr("drain_4", 1'b1);
    total++; if (jmpsrc !== 32'hA30) begin bad++; $display("FAIL drain_4_src got=%h exp=a30", jmpsrc); end
    tick(); chk_wr("drain_done", 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b exp=0", busy); end
    total++; if (wr_cnt !== 16'd8) begin bad++; $display("FAIL drain_wr_cnt got=%0d exp=8", wr_cnt); end
  endtask

  task automatic test_async_reset();
    wr_hold = 1;
    drive_lane1(1, 32'hC00, 32'hD00);
    drive_lane2(1, 32'hC10, 32'hD10);
    tick();
    idle_lanes();
    drive_lane1(1, 32'hC20, 32'hD20);
    tick();                               // three entries queued
    idle_lanes();
    wr_hold = 0;
    tick();                               // head issued
    chk_wr("ar_inflight", 1'b1);
    #1 rst = 1;
    exp_q.delete();
    #1;
    chk_wr("ar_drop", 1'b0);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
    total++; if (wr_cnt !== 16'd0) begin bad++; $display("FAIL ar_wr_cnt got=%0d exp=0", wr_cnt); end
    tick(); tick();
    rst = 0;
    repeat (5) begin
      tick();
      chk_wr("ar_no_stale", 1'b0);
    end
    total++; if (upd_rdy !== 1'b1) begin bad++; $display("FAIL ar_rdy got=%b exp=1", upd_rdy); end
  endtask

  // Random traffic with a bench-side occupancy model; sources come from a
  // small set so that merges occur.
  task automatic test_back_to_back();
    int m_cnt = 0;
    int push;
    int pop;
    logic m_rdy;
    logic [PW-1:0] s1, s2, t1, t2;
    logic v1, v2, k1, k2;
    wr_hold = 0;
    for (int i = 0; i < 40; i++) begin
      m_rdy = (m_cnt <= 2);
      total++;
      if (upd_rdy !== m_rdy) begin bad++; $display("FAIL b2b_rdy i=%0d got=%b exp=%b", i, upd_rdy, m_rdy); end
      v1 = 1'($urandom_range(0, 1)); k1 = ($urandom_range(0, 3) != 0);
      v2 = 1'($urandom_range(0, 1)); k2 = ($urandom_range(0, 3) != 0);
      s1 = 32'h4000 + 32'($urandom_range(0, 3)) * 8;
      s2 = 32'h4000 + 32'($urandom_range(0, 3)) * 8;
      t1 = 32'($urandom_range(0, 65535));
      t2 = 32'($urandom_range(0, 65535));
      idle_lanes();
      if (v1) drive_lane1(k1, s1, t1);
      if (v2) drive_lane2(k2, s2, t2);
      push = 0;
      if (m_rdy) begin
        if (v1 && k1 && v2 && k2 && s1 == s2) begin
          exp_q.push_back({s2, t2}); push = 1;
        end else begin
          if (v1 && k1) begin exp_q.push_back({s1, t1}); push++; end
          if (v2 && k2) begin exp_q.push_back({s2, t2}); push++; end
        end
      end
      pop = (m_cnt > 0) ? 1 : 0;
      m_cnt = m_cnt + push - pop;
      rand_pushes += push;
      tick();
    end
    idle_lanes();
    repeat (8) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", busy); end
    total++; if (wr_cnt !== CW'(rand_pushes)) begin bad++; $display("FAIL b2b_wr_cnt got=%0d exp=%0d", wr_cnt, rand_pushes); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual_distinct();
    test_merge_and_not_taken();
    test_hold_full();
    test_async_reset();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d pending writes exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
